// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared types and constants for the mem-stage data cache responder.
//   MSHR_DEPTH   : number of outstanding load misses (must track the mem
//                  stage's own outstanding-miss limit)
//   mshr_entry_t : one outstanding load miss {word address, dest register}
//   miss_state_t : miss engine states
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int MSHR_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  regD;
    } mshr_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } miss_state_t;

endpackage

// File: rtl/mshr_fifo.sv
// ---------------------------------------------------------------------------
// mshr_fifo
// In-order circular FIFO of outstanding load misses.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : append push_entry_i (ignored when full)
//   push_entry_i  : entry to append
//   pop_i         : retire the head entry (ignored when empty)
//   head_o        : oldest entry
//   full_o/empty_o: occupancy flags derived from the entry count
//   cmp_addr_i    : word-aligned address to look up
//   match_o       : per-slot hit of cmp_addr_i against valid entries
// ---------------------------------------------------------------------------
module mshr_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = MSHR_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  mshr_entry_t       push_entry_i,
    input  logic              pop_i,
    output mshr_entry_t       head_o,
    output logic              full_o,
    output logic              empty_o,
    input  logic [31:0]       cmp_addr_i,
    output logic [DEPTH-1:0]  match_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mshr_entry_t      entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = entries_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_q[i] && (entries_q[i].addr == cmp_addr_i);
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// ---------------------------------------------------------------------------
// dcache_responder
// Non-blocking, direct-mapped, write-through data cache answering the
// mem-stage mmio interface, with an in-order MSHR for load misses and a
// single-port in-order main-memory interface.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   mmio_req/lw/addr/data_write/regD : request from the mem stage
//   mmio_data_read    : hit data or fill data
//   hit_ack           : load hit, or store accepted by memory
//   miss_store        : load miss allocated in the MSHR
//   passive_stall     : request refused, mem stage must re-request
//   load_done_stall   : fill complete, write mmio_data_read to regD_done
//   regD_done         : destination register of the completed fill
//   mem_req/we/addr/wdata, mem_gnt : memory request channel
//   mem_rvalid/rdata  : memory read return (one outstanding, in order)
// ---------------------------------------------------------------------------
module dcache_responder #(
    parameter int LINES      = 64,
    parameter int MSHR_DEPTH = dcache_pkg::MSHR_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmio_req,
    input  logic        mmio_lw,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_data_write,
    input  logic [4:0]  mmio_regD,
    output logic [31:0] mmio_data_read,
    output logic        hit_ack,
    output logic        miss_store,
    output logic        passive_stall,
    output logic        load_done_stall,
    output logic [4:0]  regD_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    import dcache_pkg::*;

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[31:IDX_W+2];
    endfunction

    // Cache lines
    logic [LINES-1:0] line_vld_q;
    logic [TAG_W-1:0] line_tag_q  [LINES];
    logic [31:0]      line_data_q [LINES];

    // Captured request
    logic        req_q;
    logic        req_lw_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [4:0]  req_regd_q;

    // Completed fill waiting to be presented
    logic        done_q;
    logic [4:0]  done_regd_q;
    logic [31:0] done_data_q;

    miss_state_t state_q, state_d;

    mshr_entry_t           head;
    mshr_entry_t           push_entry;
    logic [MSHR_DEPTH-1:0] mshr_match;
    logic                  mshr_full;
    logic                  mshr_empty;
    logic                  push;
    logic                  fill;
    logic                  store_own;
    logic                  store_wr;
    logic                  line_hit;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      head_idx;
    logic                  unused_addr_bits;

    // Byte offset is irrelevant for a word cache.
    assign unused_addr_bits = ^mmio_addr[1:0];

    assign req_idx    = idx_of(req_addr_q);
    assign head_idx   = idx_of(head.addr);
    assign line_hit   = line_vld_q[req_idx] && (line_tag_q[req_idx] == tag_of(req_addr_q));
    assign push_entry = '{addr: req_addr_q, regD: req_regd_q};
    assign fill       = (state_q == WAIT) && mem_rvalid;

    mshr_fifo #(
        .DEPTH(MSHR_DEPTH)
    ) u_mshr (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (fill),
        .head_o      (head),
        .full_o      (mshr_full),
        .empty_o     (mshr_empty),
        .cmp_addr_i  (req_addr_q),
        .match_o     (mshr_match)
    );

    // Request capture stage boundary: address is word-aligned on capture
    // so MSHR matching and memory addresses need no further masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            req_q   <= mmio_req;
            done_q  <= fill;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mmio_req) begin
            req_lw_q    <= mmio_lw;
            req_addr_q  <= {mmio_addr[31:2], 2'b00};
            req_wdata_q <= mmio_data_write;
            req_regd_q  <= mmio_regD;
        end
        if (fill) begin
            done_regd_q <= head.regD;
            done_data_q <= mem_rdata;
        end
    end

    // Response stage: exactly one control output per captured request;
    // a pending fill pre-empts and drops the request.
    always_comb begin
        hit_ack         = 1'b0;
        miss_store      = 1'b0;
        passive_stall   = 1'b0;
        load_done_stall = 1'b0;
        regD_done       = 5'd0;
        mmio_data_read  = 32'd0;
        push            = 1'b0;
        store_own       = 1'b0;
        store_wr        = 1'b0;
        if (done_q) begin
            load_done_stall = 1'b1;
            regD_done       = done_regd_q;
            mmio_data_read  = done_data_q;
        end else if (req_q) begin
            if (|mshr_match) begin
                passive_stall = 1'b1;
            end else if (req_lw_q) begin
                if (line_hit) begin
                    hit_ack        = 1'b1;
                    mmio_data_read = line_data_q[req_idx];
                end else if (!mshr_full) begin
                    miss_store = 1'b1;
                    push       = 1'b1;
                end else begin
                    passive_stall = 1'b1;
                end
            end else begin
                // Write-through store takes the memory port this cycle.
                store_own = 1'b1;
                if (mem_gnt) begin
                    hit_ack  = 1'b1;
                    store_wr = line_hit;
                end else begin
                    passive_stall = 1'b1;
                end
            end
        end
    end

    // Memory port: a store in its response cycle has priority over a miss read.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (store_own) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req_addr_q;
            mem_wdata = req_wdata_q;
        end else if (state_q == ISSUE) begin
            mem_req  = 1'b1;
            mem_addr = head.addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!mshr_empty) state_d = ISSUE;
            ISSUE:   if (!store_own && mem_gnt) state_d = WAIT;
            WAIT:    if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line update stage boundary: a fill wins over a same-cycle store to
    // the same index, since the fill installs a different tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_vld_q <= '0;
        end else if (fill) begin
            line_vld_q[head_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (store_wr) begin
            line_data_q[req_idx] <= req_wdata_q;
        end
        if (fill) begin
            line_data_q[head_idx] <= mem_rdata;
            line_tag_q[head_idx]  <= tag_of(head.addr);
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// ---------------------------------------------------------------------------
// tb_dcache_responder
// Scoreboard bench for dcache_responder: each driven request (or memory
// fill) pushes its expected response; a negedge monitor pops and compares
// whenever the DUT raises a control output. Miss read addresses are checked
// against a second queue as the miss engine issues them.
// ---------------------------------------------------------------------------
module tb_dcache_responder;

    localparam logic [3:0] K_HIT  = 4'b0001;
    localparam logic [3:0] K_MISS = 4'b0010;
    localparam logic [3:0] K_PASS = 4'b0100;
    localparam logic [3:0] K_DONE = 4'b1000;

    typedef struct packed {
        logic [3:0]  kind;
        logic        st;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mmio_req = 1'b0;
    logic        mmio_lw = 1'b0;
    logic [31:0] mmio_addr = '0;
    logic [31:0] mmio_data_write = '0;
    logic [4:0]  mmio_regD = '0;
    logic [31:0] mmio_data_read;
    logic        hit_ack;
    logic        miss_store;
    logic        passive_stall;
    logic        load_done_stall;
    logic [4:0]  regD_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    logic [31:0] rdq[$];
    logic [3:0]  obs;
    exp_t        e;

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mmio_req       (mmio_req),
        .mmio_lw        (mmio_lw),
        .mmio_addr      (mmio_addr),
        .mmio_data_write(mmio_data_write),
        .mmio_regD      (mmio_regD),
        .mmio_data_read (mmio_data_read),
        .hit_ack        (hit_ack),
        .miss_store     (miss_store),
        .passive_stall  (passive_stall),
        .load_done_stall(load_done_stall),
        .regD_done      (regD_done),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic lw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [3:0] kind, input logic [31:0] edata);
        exp_q.push_back('{kind: kind, st: !lw, data: edata, rd: rd, addr: addr});
        if (kind == K_MISS) rdq.push_back(addr);
        mmio_req        = 1'b1;
        mmio_lw         = lw;
        mmio_addr       = addr;
        mmio_data_write = wd;
        mmio_regD       = rd;
        tick();
        mmio_req = 1'b0;
        wait_drain();
    endtask

    task automatic fill(input logic [31:0] data, input logic [4:0] rd);
        repeat (3) tick();
        exp_q.push_back('{kind: K_DONE, st: 1'b0, data: data, rd: rd, addr: 32'd0});
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        wait_drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 32'({load_done_stall, passive_stall, miss_store, hit_ack}), 32'd0);
        chk({tag, "_mem"}, 32'({mem_req, mem_we}), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata"}, mmio_data_read, 32'd0);
        chk({tag, "_regd"}, 32'(regD_done), 32'd0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            obs = {load_done_stall, passive_stall, miss_store, hit_ack};
            if (obs != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(obs), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_kind", 32'(obs), 32'(e.kind));
                    if (e.kind == K_DONE) begin
                        chk("fill_data", mmio_data_read, e.data);
                        chk("regD_done", 32'(regD_done), 32'(e.rd));
                    end else if (e.kind == K_HIT && !e.st) begin
                        chk("hit_data", mmio_data_read, e.data);
                    end else if (e.kind == K_HIT && e.st) begin
                        chk("st_we", 32'({mem_req, mem_we}), 32'd3);
                        chk("st_addr", mem_addr, e.addr);
                        chk("st_wdata", mem_wdata, e.data);
                    end
                end
            end
            if (mem_req && !mem_we && mem_gnt) begin
                if (rdq.size() == 0) chk("unexpected_rd", mem_addr, 32'd0);
                else chk("rd_addr", mem_addr, rdq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Cold miss, fill, then hit.
        send(1'b1, 32'h100, 32'h0, 5'd5, K_MISS, 32'h0);
        fill(32'hCAFE0001, 5'd5);
        send(1'b1, 32'h100, 32'h0, 5'd6, K_HIT, 32'hCAFE0001);

        // Store hit updates the line.
        send(1'b0, 32'h100, 32'h12345678, 5'd0, K_HIT, 32'h12345678);
        send(1'b1, 32'h100, 32'h0, 5'd6, K_HIT, 32'h12345678);

        // Refused store, retried store, no write-allocate on store miss.
        mem_gnt = 1'b0;
        send(1'b0, 32'h104, 32'hAAAA5555, 5'd0, K_PASS, 32'h0);
        mem_gnt = 1'b1;
        send(1'b0, 32'h104, 32'hAAAA5555, 5'd0, K_HIT, 32'hAAAA5555);
        send(1'b1, 32'h104, 32'h0, 5'd7, K_MISS, 32'h0);
        fill(32'hAAAA5555, 5'd7);

        // MSHR fills up at four; fills complete in order.
        send(1'b1, 32'h400, 32'h0, 5'd1, K_MISS, 32'h0);
        send(1'b1, 32'h500, 32'h0, 5'd2, K_MISS, 32'h0);
        send(1'b1, 32'h600, 32'h0, 5'd3, K_MISS, 32'h0);
        send(1'b1, 32'h700, 32'h0, 5'd4, K_MISS, 32'h0);
        send(1'b1, 32'h800, 32'h0, 5'd8, K_PASS, 32'h0);
        fill(32'hD0000001, 5'd1);
        fill(32'hD0000002, 5'd2);
        fill(32'hD0000003, 5'd3);
        fill(32'hD0000004, 5'd4);
        send(1'b1, 32'h700, 32'h0, 5'd4, K_HIT, 32'hD0000004);

        // Request to an address still in the MSHR is refused until drained.
        send(1'b1, 32'h200, 32'h0, 5'd9, K_MISS, 32'h0);
        send(1'b1, 32'h200, 32'h0, 5'd10, K_PASS, 32'h0);
        send(1'b1, 32'h202, 32'h0, 5'd10, K_PASS, 32'h0);
        fill(32'hBEEF0200, 5'd9);
        send(1'b1, 32'h200, 32'h0, 5'd10, K_HIT, 32'hBEEF0200);

        // Fill presentation pre-empts a same-cycle hit, which is then retried.
        send(1'b1, 32'h300, 32'h0, 5'd11, K_MISS, 32'h0);
        repeat (3) tick();
        exp_q.push_back('{kind: K_DONE, st: 1'b0, data: 32'h33330300, rd: 5'd11, addr: 32'd0});
        mmio_req   = 1'b1;
        mmio_lw    = 1'b1;
        mmio_addr  = 32'h104;
        mmio_regD  = 5'd12;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h33330300;
        tick();
        mmio_req   = 1'b0;
        mem_rvalid = 1'b0;
        wait_drain();
        send(1'b1, 32'h104, 32'h0, 5'd12, K_HIT, 32'hAAAA5555);

        // Reset while waiting on a read: late return ignored, cache invalid.
        send(1'b1, 32'h108, 32'h0, 5'd13, K_MISS, 32'h0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADDEAD;
        tick();
        mem_rvalid = 1'b0;
        repeat (3) tick();
        send(1'b1, 32'h104, 32'h0, 5'd14, K_MISS, 32'h0);
        fill(32'h0F0F0104, 5'd14);
        send(1'b1, 32'h104, 32'h0, 5'd15, K_HIT, 32'h0F0F0104);

        repeat (3) tick();
        chk("leftover_exp", 32'(exp_q.size()), 32'd0);
        chk("leftover_rd", 32'(rdq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
